sic_mem_lock_arbiter: RTL

Arbitrates the single data-memory port among NUM_SIC memory-capable SIC execution units. Each SIC raises a lock request tagged with its issue_id. The arbiter grants the oldest requester relative to the head issue_id and muxes the owner's address, wdata and wen onto the memory port. It sits between the sic_exec_mem instances and the data memory, and drives their mem_grant inputs.

---
 rtl/sic_mem_lock_arbiter_pkg.sv | 26 ++
 rtl/sic_mem_lock_arbiter_picker.sv | 35 +++
 rtl/sic_mem_lock_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sic_mem_lock_arbiter_pkg.sv
// Shared types for the SIC data-memory lock path.
// Request/lock bundles are common to sic_exec_mem and the arbiter.
package sic_mem_lock_arbiter_pkg;

    localparam int SIC_ID_W = 6;
    localparam int ADDR_W   = 30;
    localparam int DATA_W   = 32;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } arb_state_e;

    typedef struct packed {
        logic                req;
        logic                release_lock;
        logic [SIC_ID_W-1:0] req_issue_id;
    } mem_rpl_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wen;
    } mem_req_t;

endpackage

// File: rtl/sic_mem_lock_arbiter_picker.sv
// Oldest-first picker: smallest (id - head) wins, lowest index on ties.
// Shared with the issue scheduler, so kept free of arbiter state.
module sic_age_picker #(
    parameter int N   = 4,
    parameter int IDW = 6,
    parameter int IW  = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N*IDW-1:0] ids,
    input  logic [IDW-1:0]   head,
    input  logic [N-1:0]     excl,
    output logic [IW-1:0]    win,
    output logic             valid
);

    logic [IDW-1:0] age;
    logic [IDW-1:0] best;

    always_comb begin
        valid = 1'b0;
        win   = '0;
        best  = '0;
        age   = '0;
        for (int i = 0; i < N; i++) begin
            // modular subtraction makes ages wrap with the issue_id space
            age = ids[i*IDW +: IDW] - head;
            if (req[i] && !excl[i] && (!valid || age < best)) begin
                valid = 1'b1;
                win   = IW'(i);
                best  = age;
            end
        end
    end

endmodule

// File: rtl/sic_mem_lock_arbiter.sv
// Data-memory lock arbiter: registered one-hot grant to the oldest SIC,
// combinational mux of the owner's request, and a sticky hold watchdog.
module sic_mem_lock_arbiter
    import sic_mem_lock_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = 4,
    parameter int ID_WIDTH = 6,
    parameter int MAX_HOLD = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ID_WIDTH-1:0]          head_issue_id,
    input  logic [NUM_SIC-1:0]           rpl_req,
    input  logic [NUM_SIC*ID_WIDTH-1:0]  rpl_issue_id,
    input  logic [NUM_SIC-1:0]           rpl_release,
    input  logic [NUM_SIC*ADDR_W-1:0]    sic_addr,
    input  logic [NUM_SIC*DATA_W-1:0]    sic_wdata,
    input  logic [NUM_SIC-1:0]           sic_wen,
    output logic [NUM_SIC-1:0]           mem_grant,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         mem_wen,
    output logic                         hold_err
);

    localparam int IW = $clog2(NUM_SIC);
    localparam int CW = $clog2(MAX_HOLD + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_HOLD + 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_err_q, hold_err_d;

    logic [NUM_SIC-1:0] excl;
    logic [IW-1:0]      win;
    logic               win_vld;
    logic               tenure_end;
    mem_req_t           reqs [NUM_SIC];

    always_comb begin
        excl = '0;
        if (state_q == ST_GRANTED) excl[owner_q] = 1'b1;
    end

    sic_age_picker #(
        .N   (NUM_SIC),
        .IDW (ID_WIDTH),
        .IW  (IW)
    ) u_picker (
        .req   (rpl_req),
        .ids   (rpl_issue_id),
        .head  (head_issue_id),
        .excl  (excl),
        .win   (win),
        .valid (win_vld)
    );

    assign tenure_end = (state_q == ST_GRANTED) &&
                        (rpl_release[owner_q] || !rpl_req[owner_q]);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        hold_err_d = hold_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_GRANTED;
                    owner_d    = win;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANTED: begin
                if (tenure_end) begin
                    // hand over in the same cycle to avoid a bubble
                    hold_cnt_d = '0;
                    if (win_vld) owner_d = win;
                    else         state_d = ST_IDLE;
                end else begin
                    if (hold_cnt_q != CNT_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_d == CNT_SAT) hold_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            hold_err_q <= hold_err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SIC; i++) begin
            reqs[i].addr  = sic_addr[i*ADDR_W +: ADDR_W];
            reqs[i].wdata = sic_wdata[i*DATA_W +: DATA_W];
            reqs[i].wen   = sic_wen[i];
        end
    end

    always_comb begin
        mem_grant = '0;
        if (state_q == ST_GRANTED) mem_grant[owner_q] = 1'b1;
    end

    assign mem_addr  = reqs[owner_q].addr;
    assign mem_wdata = reqs[owner_q].wdata;
    assign mem_wen   = (state_q == ST_GRANTED) && reqs[owner_q].wen;
    assign hold_err  = hold_err_q;

endmodule
